mem_load_arbiter: RTL
=====================

MEM_LOAD_ARBITER -- requirements
Module: mem_load_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter DEPTH, default 32, loadable words; SHALL equal 2**ADDR_W.
REQ-004 CLOCK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU requests a memory access this cycle.
REQ-007 cpu_we  in  1  CPU access is a write.
REQ-008 cpu_addr  in  ADDR_W  CPU address.
REQ-009 cpu_wdata  in  DATA_W  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access performed this cycle.
REQ-011 cpu_hold  out  1  CPU must stall; memory owned by the loader.
REQ-012 cpu_rdata  out  DATA_W  read data to the CPU.
REQ-013 ld_start  in  1  one-cycle pulse; begin program load.
REQ-014 ld_enter  in  1  one-cycle pulse; commit ld_data at the current load address.
REQ-015 ld_stop  in  1  one-cycle pulse; end load early.
REQ-016 ld_data  in  DATA_W  word from the switches.
REQ-017 ld_addr  out  ADDR_W  next address the loader will write.
REQ-018 ld_done  out  1  one-cycle pulse at load end; used by the top level to reset the CPU.
REQ-019 mem_addr  out  ADDR_W  shared single-port RAM address.
REQ-020 mem_we  out  1  RAM write enable.
REQ-021 mem_wdata  out  DATA_W  RAM write data.
REQ-022 mem_rdata  in  DATA_W  RAM read data.
REQ-023 state  out  2  FSM state for LED debug.

Function
REQ-024 FSM states and encodings: S_CPU=0, S_LWAIT=1, S_LWR=2, S_LDONE=3.
REQ-025 In S_CPU: cpu_gnt=cpu_req, cpu_hold=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we (all combinational).
REQ-026 In S_CPU, ld_start SHALL do two things: grant any CPU access in the same cycle, and cause transition to S_LWAIT with load counter cleared to 0.
REQ-027 In S_LWAIT, S_LWR and S_LDONE: cpu_gnt=0, cpu_hold=1, and CPU requests are ignored (not queued).
REQ-028 In S_LWAIT: mem_we=0.
REQ-029 In S_LWAIT, ld_stop SHALL cause transition to S_LDONE.
REQ-030 In S_LWAIT, ld_enter without ld_stop SHALL latch ld_data into a write register and cause transition to S_LWR.
REQ-031 When ld_stop and ld_enter coincide in S_LWAIT, ld_stop wins and no word is written.
REQ-032 In S_LWR (exactly one cycle): mem_we=1, mem_addr=load counter, mem_wdata=latched word.
REQ-033 From S_LWR: if counter==DEPTH-1, go to S_LDONE with counter wrapping to 0; else increment the counter and go to S_LWAIT.
REQ-034 In S_LDONE (exactly one cycle): ld_done=1, mem_we=0; then go to S_CPU.
REQ-035 ld_addr SHALL always equal the load counter.
REQ-036 ld_start outside S_CPU, and ld_enter/ld_stop outside S_LWAIT, SHALL be ignored.
REQ-037 cpu_rdata SHALL equal mem_rdata combinationally in all states; read latency is the RAM's own.

Reset
REQ-038 RESET low SHALL asynchronously force: state S_CPU, load counter 0, write register 0, ld_done 0.
REQ-039 Reset asserted mid-load SHALL abandon the load with no further writes; the next edge after release starts in S_CPU.

Structure
REQ-040 A shared package SHALL hold the state encodings, plus ADDR_W/DATA_W defaults for use by the CPU datapath.
REQ-041 No sub-module: single FSM plus counter, with combinational output muxing.

Verification
REQ-042 Reset, then CPU write addr 3 data 0x5A, then CPU read addr 3 -> cpu_gnt=1 both cycles; mem_we=1 on the write only; cpu_rdata=0x5A.
REQ-043 ld_start, then enter 0x11, 0x22, 0x33 -> RAM[0..2]=0x11,0x22,0x33; ld_addr=3; cpu_hold=1 throughout.
REQ-044 Load 32 words -> 32nd write goes to addr 31; ld_done pulses once; counter=0; state back to 0 next cycle.
REQ-045 ld_start coincident with CPU write addr 7 data 0x44 -> RAM[7]=0x44; next cycle state=1; later CPU requests get cpu_gnt=0.
REQ-046 In S_LWAIT, ld_enter and ld_stop in the same cycle with ld_data=0xFF -> no write; ld_done pulse; return to S_CPU.
REQ-047 RESET low one cycle after an enter (in S_LWR) -> mem_we drops immediately; state=0; ld_addr=0.

Source files
------------

// File: rtl/mem_load_arbiter_pkg.sv
// Shared definitions for the program-load arbiter: FSM encodings and the
// default memory geometry also used by the CPU datapath.
package mem_load_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_LWAIT = 2'd1,
    S_LWR   = 2'd2,
    S_LDONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_load_arbiter_if.sv
// CPU, switch-loader and single-port RAM signals of the load arbiter.
// The slave modport is the arbiter; master is the surrounding system.
interface mem_load_arbiter_if
  import mem_load_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_hold;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ld_start;
  logic              ld_enter;
  logic              ld_stop;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        state;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ld_start, ld_enter, ld_stop, ld_data,
    output mem_rdata,
    input  cpu_gnt, cpu_hold, cpu_rdata,
    input  ld_addr, ld_done,
    input  mem_addr, mem_we, mem_wdata,
    input  state
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ld_start, ld_enter, ld_stop, ld_data,
    input  mem_rdata,
    output cpu_gnt, cpu_hold, cpu_rdata,
    output ld_addr, ld_done,
    output mem_addr, mem_we, mem_wdata,
    output state
  );

endinterface

// File: rtl/mem_load_arbiter.sv
// Shares one single-port RAM between the CPU and a switch-driven program
// loader; while a load is in progress the CPU is held off entirely.
//
// state   | meaning
// S_CPU   | CPU owns the RAM, loader idle
// S_LWAIT | loading, waiting for the next enter or stop pulse
// S_LWR   | loading, writing the latched word at the load counter
// S_LDONE | load finished, one-cycle ld_done pulse
module mem_load_arbiter
  import mem_load_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input logic               clk,
  input logic               rst_n,
  mem_load_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] wreg_q, wreg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CPU;
      cnt_q   <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wreg_q  <= wreg_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wreg_d        = wreg_q;
    bus.cpu_gnt   = 1'b0;
    bus.cpu_hold  = 1'b1;
    bus.mem_addr  = cnt_q;
    bus.mem_wdata = wreg_q;
    bus.mem_we    = 1'b0;
    bus.ld_done   = 1'b0;

    unique case (state_q)
      S_CPU: begin
        // The CPU access in the ld_start cycle still completes.
        bus.cpu_gnt   = bus.cpu_req;
        bus.cpu_hold  = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_req & bus.cpu_we;
        if (bus.ld_start) begin
          state_d = S_LWAIT;
          cnt_d   = '0;
        end
      end
      S_LWAIT: begin
        if (bus.ld_stop) begin
          state_d = S_LDONE;
        end else if (bus.ld_enter) begin
          wreg_d  = bus.ld_data;
          state_d = S_LWR;
        end
      end
      S_LWR: begin
        bus.mem_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = S_LDONE;
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = S_LWAIT;
        end
      end
      S_LDONE: begin
        bus.ld_done = 1'b1;
        state_d     = S_CPU;
      end
      default: state_d = S_CPU;
    endcase
  end

  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ld_addr   = cnt_q;
  assign bus.state     = state_q;

endmodule
